// File: rtl/swb_pkg.sv
// Shared definitions for the switch-bounce generator: FSM encoding, LFSR taps and seed.
package swb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BOUNCE = 2'b01,
      SETTLE = 2'b10
   } swb_state_t;

   // Galois taps for x^16+x^14+x^13+x^11+1, shifting right.
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/sw_bounce_gen_if.sv
// Request/level in, bouncy switch plus busy/done status out.
interface sw_bounce_gen_if;
   logic req;
   logic level;
   logic sw;
   logic busy;
   logic done;

   modport master (output req, level, input sw, busy, done);
   modport slave  (input req, level, output sw, busy, done);
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with SEED on reset.
module lfsr16
   import swb_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic [15:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= SEED;
      else     r_q <= lfsr_step(r_q);
   end

   assign q = r_q;

endmodule

// File: rtl/sw_bounce_gen.sv
// Mechanical switch emulator: bounces sw BOUNCE_EDGES times then settles at the target.
// Define SWB_FIXED_GAP_EN for constant MIN_GAP spacing instead of LFSR-randomised gaps.
module sw_bounce_gen
   import swb_pkg::*;
#(
   parameter int unsigned CNT_WIDTH     = 20,
   parameter int unsigned BOUNCE_EDGES  = 7,
   parameter int unsigned MIN_GAP       = 16,
   parameter int unsigned GAP_RAND_W    = 8,
   parameter int unsigned SETTLE_CYCLES = 1000,
   parameter logic        INIT_LEVEL    = 1'b0,
   parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
   input  logic            clk,
   input  logic            rst,
   sw_bounce_gen_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] SETTLE_INIT = CNT_WIDTH'(SETTLE_CYCLES - 1);

   swb_state_t           r_state;
   logic                 r_sw;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_tgt;
   logic [7:0]           r_edges_left;
   logic [CNT_WIDTH-1:0] r_gap_cnt;
   logic [CNT_WIDTH-1:0] r_settle_cnt;
   logic [CNT_WIDTH-1:0] w_gap;

`ifdef SWB_FIXED_GAP_EN
   assign w_gap = CNT_WIDTH'(MIN_GAP);
`else
   localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_RAND_W) - 32'd1);

   logic [15:0] w_lfsr;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (w_lfsr)
   );

   assign w_gap = CNT_WIDTH'(MIN_GAP) + CNT_WIDTH'(w_lfsr & GAP_MASK);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sw         <= INIT_LEVEL;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_tgt        <= INIT_LEVEL;
         r_edges_left <= '0;
         r_gap_cnt    <= '0;
         r_settle_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req) begin
                  r_tgt  <= bus.level;
                  r_busy <= 1'b1;
                  if (bus.level != r_sw) begin
                     r_state      <= BOUNCE;
                     r_edges_left <= 8'(BOUNCE_EDGES);
                     r_gap_cnt    <= w_gap - 1'b1;
                  end else begin
                     r_state      <= SETTLE;
                     r_settle_cnt <= SETTLE_INIT;
                  end
               end
            end
            BOUNCE: begin
               if (r_gap_cnt != '0) begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end else begin
                  r_sw         <= ~r_sw;
                  r_edges_left <= r_edges_left - 8'd1;
                  if (r_edges_left == 8'd1) begin
                     r_state      <= SETTLE;
                     r_settle_cnt <= SETTLE_INIT;
                  end else begin
                     r_gap_cnt <= w_gap - 1'b1;
                  end
               end
            end
            SETTLE: begin
               r_sw <= r_tgt;
               if (r_settle_cnt != '0) begin
                  r_settle_cnt <= r_settle_cnt - 1'b1;
               end else begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sw   = r_sw;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Randomised self-checking bench for sw_bounce_gen against an edge-timeline reference model.
module tb_sw_bounce_gen;

   localparam int          MIN_GAP       = 4;
   localparam int          GAP_RAND_W    = 2;
   localparam int          BOUNCE_EDGES  = 5;
   localparam int          SETTLE_CYCLES = 10;
   localparam logic        INIT_LEVEL    = 1'b0;
   localparam logic [15:0] SEED          = 16'hACE1;
   localparam int          TAB_N         = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sw_bounce_gen_if bus ();

   sw_bounce_gen #(
      .CNT_WIDTH     (20),
      .BOUNCE_EDGES  (BOUNCE_EDGES),
      .MIN_GAP       (MIN_GAP),
      .GAP_RAND_W    (GAP_RAND_W),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL),
      .LFSR_SEED     (SEED)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          edge_no  = -1;
   logic        prev_sw;
   logic        model_sw;
   int          toggles[$];
   int          dones[$];
   int          all_tog[$];
   logic [15:0] lfsr_tab[TAB_N];

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] galois_next(input logic [15:0] v);
      logic [15:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   // Gap drawn at edge e: MIN_GAP plus the low LFSR bits held just before that edge.
   function automatic int model_gap(input int e);
`ifdef SWB_FIXED_GAP_EN
      return MIN_GAP + 0 * e;
`else
      if (e < 0 || e >= TAB_N) return -1000;
      return MIN_GAP + (int'(lfsr_tab[e]) % (1 << GAP_RAND_W));
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      edge_no++;
      #1;
      if (bus.sw !== prev_sw) begin
         toggles.push_back(edge_no);
         all_tog.push_back(edge_no);
      end
      prev_sw = bus.sw;
      if (bus.done === 1'b1) dones.push_back(edge_no);
   endtask

   task automatic apply_reset(input string tag);
      #2 rst = 1'b1;
      bus.req = 1'b0;
      #1;
      check_eq({tag, " rst_sw"},   int'(bus.sw),   int'(INIT_LEVEL));
      check_eq({tag, " rst_busy"}, int'(bus.busy), 0);
      check_eq({tag, " rst_done"}, int'(bus.done), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      edge_no  = -1;
      prev_sw  = bus.sw;
      model_sw = INIT_LEVEL;
      toggles.delete();
      dones.delete();
      all_tog.delete();
   endtask

   task automatic verify(input string tag, input int t, input logic s, input logic lvl);
      int exp_tog[$];
      int e;
      int prev;
      int exp_done;
      e = t;
      if (lvl != s)
         for (int k = 0; k < BOUNCE_EDGES; k++) begin
            e = e + model_gap(e);
            exp_tog.push_back(e);
         end
      exp_done = e + SETTLE_CYCLES;
      check_eq({tag, " toggles"}, toggles.size(), exp_tog.size());
      prev = t;
      for (int i = 0; i < toggles.size() && i < exp_tog.size(); i++) begin
         check_eq({tag, " tog_edge"}, toggles[i], exp_tog[i]);
         check_eq({tag, " gap_range"},
                  int'((toggles[i] - prev) >= MIN_GAP &&
                       (toggles[i] - prev) <= MIN_GAP + (1 << GAP_RAND_W) - 1), 1);
         prev = toggles[i];
      end
      check_eq({tag, " done_cnt"}, dones.size(), 1);
      if (dones.size() > 0) check_eq({tag, " done_edge"}, dones[0], exp_done);
      $display("xfer %s: accept=%0d from=%0d to=%0d toggles=%0d done=%0d (exp %0d)",
               tag, t, s, lvl, toggles.size(), (dones.size() > 0) ? dones[0] : -1, exp_done);
   endtask

   task automatic wait_done(input string tag, input int t, input logic lvl, input bit pulses);
      int n;
      n = 0;
      while (dones.size() == 0 && n < 600) begin
         if (pulses) begin
            bus.req   = (edge_no + 1 == t + 2) || (edge_no + 1 == t + 15);
            bus.level = ~lvl;
         end
         tick();
         n++;
      end
      if (pulses) bus.req = 1'b0;
      if (dones.size() == 0) check_eq({tag, " timeout"}, 0, 1);
      else                   check_eq({tag, " busy_at_done"}, int'(bus.busy), 0);
   endtask

   task automatic xfer(input string tag, input logic lvl, input bit pulses);
      int   t;
      logic s;
      s = model_sw;
      toggles.delete();
      dones.delete();
      bus.req   = 1'b1;
      bus.level = lvl;
      t = edge_no + 1;
      tick();
      bus.req   = 1'b0;
      bus.level = 1'($urandom);
      check_eq({tag, " busy_acc"}, int'(bus.busy), 1);
      wait_done(tag, t, lvl, pulses);
      verify(tag, t, s, lvl);
      check_eq({tag, " sw_final"}, int'(bus.sw), int'(lvl));
      model_sw = lvl;
   endtask

   task automatic run_seq(input int delays[20]);
      apply_reset("seq");
      for (int i = 0; i < 20; i++) begin
         repeat (delays[i]) tick();
         xfer("rand", ~model_sw, 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   delays[20];
      int   run_a[$];
      int   ndiff;
      int   t;
      int   n;
      int   d;
      logic lvl;
      logic s;

      bus.req   = 1'b0;
      bus.level = 1'b0;
      lfsr_tab[0] = SEED;
      for (int i = 1; i < TAB_N; i++) lfsr_tab[i] = galois_next(lfsr_tab[i-1]);

      apply_reset("por");
      xfer("rise", 1'b1, 1'b0);
      xfer("same1", 1'b1, 1'b0);
      xfer("pulse_fall", 1'b0, 1'b1);
      repeat (20) tick();
      check_eq("pulse one_done", dones.size(), 1);
      check_eq("pulse idle_busy", int'(bus.busy), 0);
      xfer("same0", 1'b0, 1'b0);

      // req held high: each return to IDLE re-accepts on the very next edge.
      lvl       = ~model_sw;
      bus.level = lvl;
      bus.req   = 1'b1;
      t = edge_no + 1;
      for (int k = 0; k < 4; k++) begin
         toggles.delete();
         dones.delete();
         s = model_sw;
         n = 0;
         tick();
         check_eq("hold busy_acc", int'(bus.busy), 1);
         while (dones.size() == 0 && n < 600) begin
            tick();
            n++;
         end
         if (dones.size() == 0) begin
            check_eq("hold timeout", 0, 1);
            break;
         end
         d = dones[0];
         check_eq("hold busy_at_done", int'(bus.busy), 0);
         verify("hold", t, s, lvl);
         model_sw  = lvl;
         lvl       = ~lvl;
         bus.level = lvl;
         t = d + 1;
      end
      bus.req = 1'b0;
      repeat (3) tick();

      for (int i = 0; i < 20; i++) delays[i] = $urandom_range(0, 5);
      run_seq(delays);
      run_a = all_tog;
      run_seq(delays);
      check_eq("repro len", all_tog.size(), run_a.size());
      ndiff = 0;
      for (int i = 0; i < all_tog.size() && i < run_a.size(); i++)
         if (all_tog[i] != run_a[i]) ndiff++;
      check_eq("repro diff", ndiff, 0);
      $display("xfer repro: run_a toggles=%0d run_b toggles=%0d diffs=%0d",
               run_a.size(), all_tog.size(), ndiff);

      // Reset after the second toggle must abort silently.
      apply_reset("mb_pre");
      toggles.delete();
      dones.delete();
      bus.req   = 1'b1;
      bus.level = 1'b1;
      tick();
      bus.req = 1'b0;
      n = 0;
      while (toggles.size() < 2 && n < 100) begin
         tick();
         n++;
      end
      check_eq("mb two_toggles", toggles.size(), 2);
      check_eq("mb no_done_yet", dones.size(), 0);
      check_eq("mb sw_before", int'(bus.sw), 0);
      apply_reset("mb");
      repeat (3) tick();
      check_eq("mb no_done_after", dones.size(), 0);
      check_eq("mb sw_idle", int'(bus.sw), int'(INIT_LEVEL));
      apply_reset("mb_post");
      xfer("after_rst", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
